stv_gray_sweep_ctrl: RTL and testbench

STV_GRAY_SWEEP_CTRL -- requirements
Module: stv_gray_sweep_ctrl

---
 rtl/stv_gray_sweep_ctrl.sv | 175 +++++++++++++++++
 tb/tb_stv_gray_sweep_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stv_gray_sweep_ctrl.sv
//------------------------------------------------------------------------------
// stv_gray_sweep_ctrl
//
// Presents a bounded sequence of gray-code values, one per unstalled cycle,
// starting from a commanded value and stepping up or down. At the ends of
// the range the count either wraps (modulo 2^WIDTH) or, in bounce mode,
// reverses direction. Completion is marked by a one-cycle done pulse.
//
// Parameters
//   WIDTH     gray count width (>= 2)
//   LEN_W     sweep-length field width
//   INIT_VAL  reset value of count (raw gray code)
//
// Ports
//   clk          sole clock, rising edge
//   arst         asynchronous active-high reset
//   cmd_valid    sweep command offered (accepted only in IDLE)
//   cmd_ready    controller is IDLE and can accept a command
//   cmd_start    first value to present (gray code)
//   cmd_len      number of values to present (0 = complete immediately)
//   cmd_down     initial direction, 1 = down
//   cmd_bounce   reverse at range ends instead of wrapping
//   stall        hold everything this cycle while running
//   abort        terminate the active sweep (no done pulse)
//   count        current value (gray code), straight from a register
//   count_valid  count is a presented sweep value this cycle
//   wrap_evt     the step taken this cycle wraps the range
//   busy         controller is not IDLE
//   done         one-cycle sweep-complete pulse
//------------------------------------------------------------------------------
module stv_gray_sweep_ctrl #(
    parameter int WIDTH    = 5,
    parameter int LEN_W    = 8,
    parameter int INIT_VAL = 0
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_down,
    input  logic             cmd_bounce,
    input  logic             stall,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             count_valid,
    output logic             wrap_evt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] INIT_G  = WIDTH'(INIT_VAL);
    // Gray code of binary all-ones is a single MSB set.
    localparam logic [WIDTH-1:0] UP_WRAP = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] DN_WRAP = '0;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [LEN_W-1:0] r_remaining;
    logic             r_dir;
    logic             r_bounce;

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_at_wrap;
    logic             w_flip;
    logic             w_dir_eff;
    logic             w_present;
    logic             w_more;
    logic             w_step;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = g;
        for (int unsigned k = 1; k < WIDTH; k++) begin
            b = b ^ (g >> k);
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    //--------------------------------------------------------------------------
    // Step datapath
    //--------------------------------------------------------------------------
    always_comb begin
        w_bin     = gray2bin(r_count);
        w_at_wrap = r_dir ? (r_count == DN_WRAP) : (r_count == UP_WRAP);
        // In bounce mode, leaving a wrap point reverses direction and the step
        // is taken in the new direction within the same cycle.
        w_flip    = r_bounce & w_at_wrap;
        w_dir_eff = r_dir ^ w_flip;
        if (w_dir_eff) begin
            w_bin_next = w_bin - WIDTH'(1);
        end else begin
            w_bin_next = w_bin + WIDTH'(1);
        end
        w_gray_next = bin2gray(w_bin_next);
        w_present   = (r_state == S_RUN) & ~stall & ~abort;
        // The last presentation completes the sweep without stepping.
        w_more      = (r_remaining > LEN_W'(1));
        w_step      = w_present & w_more;
    end

    //--------------------------------------------------------------------------
    // Control FSM and state registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state     <= S_IDLE;
            r_count     <= INIT_G;
            r_remaining <= '0;
            r_dir       <= 1'b0;
            r_bounce    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // abort is ignored here; a command offered is accepted.
                    if (cmd_valid) begin
                        r_count     <= cmd_start;
                        r_remaining <= cmd_len;
                        r_dir       <= cmd_down;
                        r_bounce    <= cmd_bounce;
                        r_state     <= (cmd_len != '0) ? S_RUN : S_DONE;
                    end
                end

                S_RUN: begin
                    // abort outranks stall and completion; count is held.
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (!stall) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_more) begin
                            r_count <= w_gray_next;
                            r_dir   <= w_dir_eff;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign count       = r_count;
    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = ~cmd_ready;
    assign count_valid = w_present;
    assign wrap_evt    = w_step & ~r_bounce & w_at_wrap;
    // An abort arriving in DONE swallows the completion pulse.
    assign done        = (r_state == S_DONE) & ~abort;

endmodule

// File: tb/tb_stv_gray_sweep_ctrl.sv
module tb_stv_gray_sweep_ctrl;

    localparam int W    = 3;
    localparam int LW   = 8;
    localparam int INIT = 6;   // raw gray 110

    logic          clk = 1'b0;
    logic          arst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_start;
    logic [LW-1:0] cmd_len;
    logic          cmd_down;
    logic          cmd_bounce;
    logic          stall;
    logic          abort;
    logic [W-1:0]  count;
    logic          count_valid;
    logic          wrap_evt;
    logic          busy;
    logic          done;

    stv_gray_sweep_ctrl #(
        .WIDTH   (W),
        .LEN_W   (LW),
        .INIT_VAL(INIT)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_len    (cmd_len),
        .cmd_down   (cmd_down),
        .cmd_bounce (cmd_bounce),
        .stall      (stall),
        .abort      (abort),
        .count      (count),
        .count_valid(count_valid),
        .wrap_evt   (wrap_evt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] val;
        logic         wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    logic s_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [W-1:0] v, input logic w);
        exp_t e;
        e.val  = v;
        e.wrap = w;
        exp_q.push_back(e);
    endtask

    // One clock: sample on the falling edge, return just after the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        s_ready = cmd_ready;
        if (count_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'(count_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("count", 32'(count), 32'(e.val));
                chk("wrap_evt", 32'(wrap_evt), 32'(e.wrap));
            end
        end
        if (done) begin
            n_done++;
            chk("done_after_last_value", 32'(exp_q.size()), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] st, input logic [LW-1:0] ln,
                         input logic dn, input logic bn);
        n_done     = 0;
        chk("issue_ready", 32'(cmd_ready), 32'd1);
        cmd_start  = st;
        cmd_len    = ln;
        cmd_down   = dn;
        cmd_bounce = bn;
        cmd_valid  = 1'b1;
        cyc();
        cmd_valid  = 1'b0;
    endtask

    task automatic drain(input logic [W-1:0] final_cnt, input int exp_done, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_within_budget", 32'(ok), 32'd1);
        chk("done_pulses", 32'(n_done), 32'(exp_done));
        chk("final_count", 32'(count), 32'(final_cnt));
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] b;
        arst       = 1'b1;
        cmd_valid  = 1'b0;
        cmd_start  = '0;
        cmd_len    = '0;
        cmd_down   = 1'b0;
        cmd_bounce = 1'b0;
        stall      = 1'b0;
        abort      = 1'b0;

        // Reset state
        #3;
        chk("rst_count", 32'(count), 32'h6);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(count_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wrap", 32'(wrap_evt), 32'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        cyc();

        // Up sweep 110,111,101
        push(3'b110, 1'b0); push(3'b111, 1'b0); push(3'b101, 1'b0);
        issue(3'b110, 8'd3, 1'b0, 1'b0);
        chk("busy_in_run", 32'(busy), 32'd1);
        drain(3'b101, 1, 20);

        // Up wrap 100 -> 000
        push(3'b100, 1'b1); push(3'b000, 1'b0);
        issue(3'b100, 8'd2, 1'b0, 1'b0);
        drain(3'b000, 1, 20);

        // Down wrap 001,000,100
        push(3'b001, 1'b0); push(3'b000, 1'b1); push(3'b100, 1'b0);
        issue(3'b001, 8'd3, 1'b1, 1'b0);
        drain(3'b100, 1, 20);

        // Down bounce 001,000,001,011 with a stray command mid-sweep
        push(3'b001, 1'b0); push(3'b000, 1'b0); push(3'b001, 1'b0); push(3'b011, 1'b0);
        issue(3'b001, 8'd4, 1'b1, 1'b1);
        cmd_valid = 1'b1; cmd_start = 3'b111; cmd_len = 8'd1;
        cyc();
        cmd_valid = 1'b0;
        drain(3'b011, 1, 20);

        // Bounce starting at the opposite end steps normally
        push(3'b100, 1'b0); push(3'b101, 1'b0);
        issue(3'b100, 8'd2, 1'b1, 1'b1);
        drain(3'b101, 1, 20);

        // Stall for two cycles after the first value
        push(3'b000, 1'b0); push(3'b001, 1'b0); push(3'b011, 1'b0);
        issue(3'b000, 8'd3, 1'b0, 1'b0);
        cyc();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_valid_low", 32'(count_valid), 32'd0);
            chk("stall_hold", 32'(count), 32'(3'b001));
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        drain(3'b011, 1, 20);

        // Abort during second RUN cycle
        push(3'b010, 1'b0);
        issue(3'b010, 8'd5, 1'b0, 1'b0);
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        drain(3'b110, 0, 5);

        // len=0 command accepted while abort is high in IDLE
        abort = 1'b1;
        issue(3'b111, 8'd0, 1'b0, 1'b0);
        abort = 1'b0;
        drain(3'b111, 1, 5);

        // Abort while in DONE suppresses the pulse
        push(3'b011, 1'b0);
        issue(3'b011, 8'd1, 1'b0, 1'b0);
        cyc();
        abort = 1'b1;
        @(negedge clk);
        chk("abort_in_done_busy", 32'(busy), 32'd1);
        chk("abort_in_done_no_pulse", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        drain(3'b011, 0, 5);

        // Maximum length: 255 values, up, non-bounce
        for (int i = 0; i < 255; i++) begin
            b = 3'(i % 8);
            push(b ^ (b >> 1), (b == 3'd7) && (i != 254));
        end
        issue(3'b000, 8'd255, 1'b0, 1'b0);
        drain(3'b101, 1, 300);

        // Reset mid-RUN
        push(3'b000, 1'b0); push(3'b001, 1'b0);
        issue(3'b000, 8'd10, 1'b0, 1'b0);
        cyc();
        cyc();
        arst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'h6);
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        chk("arst_valid", 32'(count_valid), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        cyc();
        arst = 1'b0;
        chk("arst_no_done", 32'(n_done), 32'd0);
        exp_q.delete();

        // First command after reset
        push(3'b101, 1'b0);
        issue(3'b101, 8'd1, 1'b0, 1'b0);
        drain(3'b101, 1, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
